// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by fetch and decode.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_BEQ = 3'b101;
    localparam logic [2:0] OP_SW  = 3'b110;
    localparam logic [2:0] OP_LW  = 3'b111;

endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: instruction output register with valid/ready handshake toward decode.
// A squash clears the valid flag even when decode is taking the instruction that cycle.
module fetch_out_reg #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               ready_i,
    input  logic               squash_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = squash_i ? 1'b0 : load_i ? 1'b1 : (valid_q && ready_i) ? 1'b0 : valid_q;
        instr_d = load_i ? data_i : instr_q;
        pc_d    = load_i ? pc_i : pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing one-at-a-time imem requests and presenting instructions to decode.
// Define INSTRUCTION_FETCH_PERF_EN to add saturating fetched/flushed performance counters.
module instruction_fetch import cpu_pkg::*; #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt
`ifdef INSTRUCTION_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    fetch_state_e      state_q, state_d, resume;
    logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic              flush_q, flush_d;
    logic              load, squash;

    assign resume = halt ? IDLE : REQ;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        flush_d  = flush_q;
        load     = 1'b0;
        squash   = 1'b0;
        case (state_q)
            IDLE: state_d = resume;
            REQ: begin
                if (imem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(1);
                    flush_d  = redirect_valid;
                    state_d  = WAIT;
                end else if (halt) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // A response landing in the redirect cycle is wrong-path and dropped directly.
                if (imem_rsp_valid) begin
                    if (flush_q || redirect_valid) begin
                        flush_d = 1'b0;
                        state_d = resume;
                    end else begin
                        load    = 1'b1;
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    flush_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    squash  = 1'b1;
                    state_d = resume;
                end else if (instr_valid && instr_ready) begin
                    state_d = resume;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) pc_d = redirect_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            flush_q  <= flush_d;
        end
    end

    assign imem_req_valid = state_q == REQ;
    assign imem_req_addr  = pc_q;

    fetch_out_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .data_i   (imem_rsp_data),
        .pc_i     (req_pc_q),
        .ready_i  (instr_ready),
        .squash_i (squash),
        .valid_o  (instr_valid),
        .instr_o  (instr),
        .pc_o     (instr_pc)
    );

`ifdef INSTRUCTION_FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d, flushed_q, flushed_d;
    logic        fire, dropped;

    assign fire    = instr_valid && instr_ready && !redirect_valid;
    assign dropped = squash || (state_q == WAIT && imem_rsp_valid && (flush_q || redirect_valid));

    always_comb begin
        fetched_d = (fire && ~&fetched_q) ? fetched_q + 32'd1 : fetched_q;
        flushed_d = (dropped && ~&flushed_q) ? flushed_q + 32'd1 : flushed_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch sequencing, stall, redirect, halt and PC wrap.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, instr_valid, instr_ready, redirect_valid, halt;
    logic [15:0] req_addr, rsp_data, instr, instr_pc, redirect_pc;
    logic        w_req_valid, w_req_ready, w_rsp_valid, w_instr_valid, w_instr_ready, w_zero;
    logic [15:0] w_req_addr, w_rsp_data, w_instr, w_instr_pc, w_redirect_pc;
`ifdef INSTRUCTION_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
`ifdef INSTRUCTION_FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    instruction_fetch #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc),
        .redirect_valid(w_zero), .redirect_pc(w_redirect_pc), .halt(w_zero)
`ifdef INSTRUCTION_FETCH_PERF_EN
        , .perf_fetched(w_perf_fetched), .perf_flushed(w_perf_flushed)
`endif
    );

    int errors = 0, checks = 0;
    int dly = 1, cnt = 0, cyc_n = 0;
    logic [15:0] raddr = '0, ovr_data = '0;
    logic        ovr_en = 1'b0, a123_seen = 1'b0;
    logic [15:0] acc_q[$], del_pc[$], del_data[$];
    int          del_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: log handshakes seen before the edge, then model the memory response after it.
    task automatic cyc();
        if (req_valid && req_ready) begin
            acc_q.push_back(req_addr);
            cnt = dly;
            raddr = req_addr;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            del_pc.push_back(instr_pc);
            del_data.push_back(instr);
            del_cyc.push_back(cyc_n);
        end
        @(posedge clk);
        #1;
        cyc_n++;
        rsp_valid = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data = ovr_en ? ovr_data : (16'h5000 ^ raddr);
            end
        end
        if (instr_valid && instr == 16'hA123) a123_seen = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; halt = 1'b1; req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; rsp_valid = 1'b0; rsp_data = '0;
        w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = '0; w_instr_ready = 1'b1;
        w_zero = 1'b0; w_redirect_pc = '0;
        #12;
        check("rst_req_valid", {31'b0, req_valid}, 0);
        check("rst_req_addr", {16'b0, req_addr}, 32'h0000);
        check("rst_instr_valid", {31'b0, instr_valid}, 0);
        check("rst_instr", {16'b0, instr}, 0);
        check("rst_instr_pc", {16'b0, instr_pc}, 0);
        check("rst_wrap_addr", {16'b0, w_req_addr}, 32'hFFFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc();
        check("wrap_req_valid", {31'b0, w_req_valid}, 1);
        check("wrap_first_addr", {16'b0, w_req_addr}, 32'hFFFF);
        check("halted_idle", {31'b0, req_valid}, 0);
        cyc();
        w_rsp_valid = 1'b1;
        w_rsp_data = 16'h7777;
        cyc();
        w_rsp_valid = 1'b0;
        check("wrap_instr_valid", {31'b0, w_instr_valid}, 1);
        check("wrap_instr_pc", {16'b0, w_instr_pc}, 32'hFFFF);
        check("wrap_instr", {16'b0, w_instr}, 32'h7777);
        cyc();
        check("wrap_second_valid", {31'b0, w_req_valid}, 1);
        check("wrap_second_addr", {16'b0, w_req_addr}, 32'h0000);
        w_req_ready = 1'b0;

        halt = 1'b0;
        for (int i = 0; i < 30 && del_pc.size() < 3; i++) cyc();
        check("seq_count", del_pc.size(), 3);
        for (int i = 0; i < del_pc.size() && i < 3; i++) begin
            check("seq_acc_addr", {16'b0, acc_q[i]}, i);
            check("seq_instr_pc", {16'b0, del_pc[i]}, i);
            check("seq_instr", {16'b0, del_data[i]}, 32'h5000 + i);
            if (i > 0) check("seq_spacing", del_cyc[i] - del_cyc[i-1], 3);
        end

        instr_ready = 1'b0;
        ovr_en = 1'b1;
        ovr_data = 16'h2005;
        cyc();
        cyc();
        ovr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'b0, instr_valid}, 1);
            check("stall_instr", {16'b0, instr}, 32'h2005);
            check("stall_pc", {16'b0, instr_pc}, 3);
            check("stall_no_req", {31'b0, req_valid}, 0);
            cyc();
        end
        instr_ready = 1'b1;
        cyc();
        check("stall_next_valid", {31'b0, req_valid}, 1);
        check("stall_next_addr", {16'b0, req_addr}, 4);

        dly = 3;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        ovr_en = 1'b1;
        ovr_data = 16'hA123;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        cyc();
        ovr_en = 1'b0;
        dly = 1;
        check("wait_rd_req_valid", {31'b0, req_valid}, 1);
        check("wait_rd_addr", {16'b0, req_addr}, 32'h0040);
        check("wait_rd_no_instr", {31'b0, instr_valid}, 0);
        cyc();
        cyc();
        check("tgt_instr_valid", {31'b0, instr_valid}, 1);
        check("tgt_instr", {16'b0, instr}, 32'h5040);
        check("tgt_instr_pc", {16'b0, instr_pc}, 32'h0040);

        redirect_valid = 1'b1;
        redirect_pc = 16'h0080;
        cyc();
        redirect_valid = 1'b0;
        check("hold_rd_squash", {31'b0, instr_valid}, 0);
        check("hold_rd_req_valid", {31'b0, req_valid}, 1);
        check("hold_rd_addr", {16'b0, req_addr}, 32'h0080);

        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        cyc();
        redirect_valid = 1'b0;
        check("acc_rd_old_addr", {16'b0, acc_q[$]}, 32'h0080);
        cyc();
        check("acc_rd_flushed", {31'b0, instr_valid}, 0);
        check("acc_rd_req_valid", {31'b0, req_valid}, 1);
        check("acc_rd_addr", {16'b0, req_addr}, 32'h0100);
        cyc();
        cyc();
        check("acc_rd_instr", {16'b0, instr}, 32'h5100);
        check("acc_rd_instr_pc", {16'b0, instr_pc}, 32'h0100);
        cyc();

        req_ready = 1'b0;
        halt = 1'b1;
        cyc();
        check("halt_drop_valid", {31'b0, req_valid}, 0);
        cyc();
        check("halt_idle_valid", {31'b0, req_valid}, 0);
        check("halt_pc_kept", {16'b0, req_addr}, 32'h0101);
        halt = 1'b0;
        req_ready = 1'b1;
        cyc();
        check("resume_valid", {31'b0, req_valid}, 1);
        check("resume_addr", {16'b0, req_addr}, 32'h0101);
        cyc();
        cyc();
        check("resume_instr", {16'b0, instr}, 32'h5101);
        check("resume_instr_pc", {16'b0, instr_pc}, 32'h0101);
        cyc();

        check("total_delivered", del_pc.size(), 6);
        check("a123_never_seen", {31'b0, a123_seen}, 0);
`ifdef INSTRUCTION_FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 6);
        check("perf_flushed", perf_flushed, 3);
        check("wrap_perf_fetched", w_perf_fetched, 1);
        check("wrap_perf_flushed", w_perf_flushed, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
